// File: rtl/scan_cmp_seq.sv
// -----------------------------------------------------------------------------
// scan_cmp_seq
//
// Bit sequencer for the scan-path compare datapath. For each byte of a scan it
// fetches the expected and mask bytes from vector memory, and hands them to the
// TDI demux. It then walks the 3-bit bit select through the byte, driving one
// TCK low/high phase pair per bit. When the byte is complete, it writes the
// demux fail byte back to the same address. Compare failures reported by the
// demux are counted, and the count saturates at all-ones.
//
// Optional feature: define SCAN_STOP_ON_FAIL_EN to end the scan after the
// first failing bit. In that case the partial byte is written and aborted is
// set. When the macro is undefined, the scan always runs the full bit_len.
//
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   start            one-cycle scan request (honoured only while idle)
//   bit_len          scan length in bits, sampled with start
//   base_adr         first byte address, sampled with start
//   busy / done      scan in progress / one-cycle end-of-scan pulse
//   aborted          last scan ended early on a failure
//   fail_cnt         failing bits of the current/last scan (saturating)
//   mem_rd, mem_adr  vector read strobe and byte address
//   mem_exp/mem_mask expected/mask byte, valid the cycle after mem_rd
//   fail_we/wdata    fail byte write strobe and data (same address)
//   dm_adr           bit select to the demux
//   dm_exp, dm_mask  expected/mask bytes to the demux
//   dm_tck, dm_tdo_en TCK phase and compare enable to the demux
//   dm_fail          demux fail register
//   dm_fail_flag     demux per-bit fail pulse, one clk after the TCK-high cycle
// -----------------------------------------------------------------------------
module scan_cmp_seq #(
   parameter int LEN_W  = 16,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  bit_len,
   input  logic [ADDR_W-1:0] base_adr,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [LEN_W-1:0]  fail_cnt,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_adr,
   input  logic [7:0]        mem_exp,
   input  logic [7:0]        mem_mask,
   output logic              fail_we,
   output logic [7:0]        fail_wdata,
   output logic [2:0]        dm_adr,
   output logic [7:0]        dm_exp,
   output logic [7:0]        dm_mask,
   output logic              dm_tck,
   output logic              dm_tdo_en,
   input  logic [7:0]        dm_fail,
   input  logic              dm_fail_flag
);

`ifdef SCAN_STOP_ON_FAIL_EN
   localparam logic STOP_EN = 1'b1;
`else
   localparam logic STOP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      TLO   = 3'd3,
      THI   = 3'd4,
      WRB   = 3'd5,
      DONE  = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [LEN_W-1:0]    fail_cnt_q, fail_cnt_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic                aborted_q, aborted_d;
   logic                abort_pend_q, abort_pend_d;
   logic [2:0]          dm_adr_q, dm_adr_d;
   logic [7:0]          dm_exp_q, dm_exp_d;
   logic [7:0]          dm_mask_q, dm_mask_d;

   logic [LEN_W-1:0]    bit_cnt_inc;
   logic [7:0]          wr_keep;

   assign bit_cnt_inc = bit_cnt_q + LEN_W'(1);

   // Keep bits 0..dm_adr of the demux fail register and zero everything above.
   // The upper bits may hold stale results from an earlier byte.
   assign wr_keep = 8'hFF >> (3'd7 - dm_adr_q);

   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      bit_cnt_d    = bit_cnt_q;
      fail_cnt_d   = fail_cnt_q;
      adr_d        = adr_q;
      aborted_d    = aborted_q;
      abort_pend_d = abort_pend_q;
      dm_adr_d     = dm_adr_q;
      dm_exp_d     = dm_exp_q;
      dm_mask_d    = dm_mask_q;

      // The fail pulse of a bit lands in the cycle after its THI. That cycle
      // is either the next bit's TLO or the byte's WRB.
      if ((state_q == TLO || state_q == WRB) && dm_fail_flag && (fail_cnt_q != '1)) begin
         fail_cnt_d = fail_cnt_q + LEN_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               len_d        = bit_len;
               adr_d        = base_adr;
               bit_cnt_d    = '0;
               fail_cnt_d   = '0;
               aborted_d    = 1'b0;
               abort_pend_d = 1'b0;
               state_d      = (bit_len != '0) ? FETCH : DONE;
            end
         end
         FETCH: state_d = LOAD;
         LOAD: begin
            dm_exp_d  = mem_exp;
            dm_mask_d = mem_mask;
            dm_adr_d  = 3'd0;
            state_d   = TLO;
         end
         TLO: begin
            if (STOP_EN && dm_fail_flag) begin
               // dm_adr has already advanced to a bit that never saw TCK high.
               // Step it back so that the write-back mask covers only the bits
               // that were actually compared.
               abort_pend_d = 1'b1;
               if (dm_adr_q != 3'd0) begin
                  dm_adr_d = dm_adr_q - 3'd1;
               end
               state_d = WRB;
            end else begin
               state_d = THI;
            end
         end
         THI: begin
            bit_cnt_d = bit_cnt_inc;
            if (dm_adr_q == 3'd7 || bit_cnt_inc == len_q) begin
               state_d = WRB;
            end else begin
               dm_adr_d = dm_adr_q + 3'd1;
               state_d  = TLO;
            end
         end
         WRB: begin
            abort_pend_d = 1'b0;
            if (STOP_EN && (abort_pend_q || dm_fail_flag)) begin
               aborted_d = 1'b1;
               state_d   = DONE;
            end else if (bit_cnt_q != len_q) begin
               adr_d   = adr_q + ADDR_W'(1);
               state_d = FETCH;
            end else begin
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         len_q        <= '0;
         bit_cnt_q    <= '0;
         fail_cnt_q   <= '0;
         adr_q        <= '0;
         aborted_q    <= 1'b0;
         abort_pend_q <= 1'b0;
         dm_adr_q     <= 3'd0;
         dm_exp_q     <= 8'h00;
         dm_mask_q    <= 8'h00;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         bit_cnt_q    <= bit_cnt_d;
         fail_cnt_q   <= fail_cnt_d;
         adr_q        <= adr_d;
         aborted_q    <= aborted_d;
         abort_pend_q <= abort_pend_d;
         dm_adr_q     <= dm_adr_d;
         dm_exp_q     <= dm_exp_d;
         dm_mask_q    <= dm_mask_d;
      end
   end

   // Strobes are pure state decodes. Reset forces IDLE, so they drop at once.
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign mem_rd     = (state_q == FETCH);
   assign fail_we    = (state_q == WRB);
   assign fail_wdata = (state_q == WRB) ? (dm_fail & wr_keep) : 8'h00;
   assign dm_tck     = (state_q == THI);
   assign dm_tdo_en  = (state_q == TLO) || (state_q == THI);
   assign aborted    = aborted_q;
   assign fail_cnt   = fail_cnt_q;
   assign mem_adr    = adr_q;
   assign dm_adr     = dm_adr_q;
   assign dm_exp     = dm_exp_q;
   assign dm_mask    = dm_mask_q;

endmodule

// File: tb/tb_scan_cmp_seq.sv
// -----------------------------------------------------------------------------
// tb_scan_cmp_seq
//
// Directed scans against scan_cmp_seq. A small behavioural demux and a vector
// memory model respond to the sequencer. The TDI model flips selected global
// bit indices, and the demux never clears its fail register between bytes,
// so the upper-bit forcing of fail_wdata is exercised.
// Each run pushes its expected reads, writes and end-of-scan results into
// queues. A free-running monitor pops and compares them as the DUT presents
// them.
// -----------------------------------------------------------------------------
module tb_scan_cmp_seq;

   localparam int LEN_W  = 16;
   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [LEN_W-1:0]  bit_len;
   logic [ADDR_W-1:0] base_adr;
   logic              busy, done, aborted;
   logic [LEN_W-1:0]  fail_cnt;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_adr;
   logic [7:0]        mem_exp, mem_mask;
   logic              fail_we;
   logic [7:0]        fail_wdata;
   logic [2:0]        dm_adr;
   logic [7:0]        dm_exp, dm_mask;
   logic              dm_tck, dm_tdo_en;
   logic [7:0]        dm_fail;
   logic              dm_fail_flag;

   // per-run stimulus
   logic [7:0]        cur_exp, cur_mask;
   logic [31:0]       flip_bits;
   logic [ADDR_W-1:0] cur_base;
   logic [ADDR_W-1:0] byte_idx;
   logic [4:0]        gidx;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   int rd_q[$];
   int wr_adr_q[$];
   int wr_dat_q[$];
   int dn_fc_q[$];
   int dn_ab_q[$];
   int dn_cyc_q[$];

   always #5 clk = ~clk;

   scan_cmp_seq #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .bit_len(bit_len),
      .base_adr(base_adr), .busy(busy), .done(done), .aborted(aborted),
      .fail_cnt(fail_cnt), .mem_rd(mem_rd), .mem_adr(mem_adr),
      .mem_exp(mem_exp), .mem_mask(mem_mask), .fail_we(fail_we),
      .fail_wdata(fail_wdata), .dm_adr(dm_adr), .dm_exp(dm_exp),
      .dm_mask(dm_mask), .dm_tck(dm_tck), .dm_tdo_en(dm_tdo_en),
      .dm_fail(dm_fail), .dm_fail_flag(dm_fail_flag)
   );

   // Vector memory: registered read, data valid the cycle after mem_rd.
   always @(posedge clk) begin
      if (mem_rd) begin
         mem_exp  <= cur_exp;
         mem_mask <= cur_mask;
      end
   end

   // Demux model: on the TCK-high cycle, compare the bit. TDI equals the
   // expected bit XOR flip. The result goes to fail[dm_adr], and the flag is
   // pulsed one clk later. The fail register is preset to all-ones at scan
   // start and never cleared afterwards.
   assign byte_idx = mem_adr - cur_base;
   assign gidx     = {byte_idx[1:0], dm_adr};

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         dm_fail_flag <= 1'b0;
      end else begin
         dm_fail_flag <= dm_tck & dm_mask[dm_adr] & flip_bits[gidx];
         if (dm_tck) begin
            dm_fail[dm_adr] <= dm_mask[dm_adr] & flip_bits[gidx];
         end else if (start && !busy) begin
            dm_fail <= 8'hFF;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got event at 0x%0h expected none", name, act);
   endtask

   // Monitor: pops expectations as the DUT presents each transaction.
   initial begin : monitor
      int bcyc;
      bcyc = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bcyc = 0;
         end else begin
            if (busy) bcyc++;
            if (mem_rd) begin
               if (rd_q.size() == 0) unexpected("rd", 32'(mem_adr));
               else begin
                  $display("rd  adr=0x%03h", mem_adr);
                  chk("rd_adr", 32'(mem_adr), rd_q.pop_front());
               end
            end
            if (fail_we) begin
               if (wr_adr_q.size() == 0) unexpected("wr", 32'(mem_adr));
               else begin
                  $display("wr  adr=0x%03h data=0x%02h", mem_adr, fail_wdata);
                  chk("wr_adr", 32'(mem_adr), wr_adr_q.pop_front());
                  chk("wr_data", 32'(fail_wdata), wr_dat_q.pop_front());
               end
            end
            if (done) begin
               if (dn_fc_q.size() == 0) unexpected("done", 32'(fail_cnt));
               else begin
                  $display("done fail_cnt=%0d aborted=%0d busy_cycles=%0d", fail_cnt, aborted, bcyc);
                  chk("fail_cnt", 32'(fail_cnt), dn_fc_q.pop_front());
                  chk("aborted", 32'(aborted), dn_ab_q.pop_front());
                  chk("busy_cycles", 32'(bcyc), dn_cyc_q.pop_front());
               end
               bcyc = 0;
               done_cnt++;
            end
         end
      end
   end

   task automatic push_done(input int fc, input int ab, input int cyc);
      dn_fc_q.push_back(fc);
      dn_ab_q.push_back(ab);
      dn_cyc_q.push_back(cyc);
   endtask

   task automatic pulse_start(input int len, input int base, input logic [7:0] e,
                              input logic [7:0] m, input logic [31:0] flips);
      @(posedge clk);
      #1;
      cur_exp   = e;
      cur_mask  = m;
      flip_bits = flips;
      cur_base  = ADDR_W'(base);
      bit_len   = LEN_W'(len);
      base_adr  = ADDR_W'(base);
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic check_drained(input string name);
      chk({name, "_rd_left"}, 32'(rd_q.size()), 0);
      chk({name, "_wr_left"}, 32'(wr_adr_q.size()), 0);
      chk({name, "_done_left"}, 32'(dn_fc_q.size()), 0);
   endtask

   task automatic run_scan(input string name, input int len, input int base,
                           input logic [7:0] e, input logic [7:0] m, input logic [31:0] flips);
      int d0;
      d0 = done_cnt;
      pulse_start(len, base, e, m, flips);
      for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
      if (done_cnt == d0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done expected done within 300 cycles", name);
      end
      @(posedge clk);
      #1;
      check_drained(name);
   endtask

   task automatic check_reset_outputs(input string name);
      chk({name, "_busy"}, 32'(busy), 0);
      chk({name, "_done"}, 32'(done), 0);
      chk({name, "_aborted"}, 32'(aborted), 0);
      chk({name, "_fail_cnt"}, 32'(fail_cnt), 0);
      chk({name, "_mem_rd"}, 32'(mem_rd), 0);
      chk({name, "_mem_adr"}, 32'(mem_adr), 0);
      chk({name, "_fail_we"}, 32'(fail_we), 0);
      chk({name, "_fail_wdata"}, 32'(fail_wdata), 0);
      chk({name, "_dm_adr"}, 32'(dm_adr), 0);
      chk({name, "_dm_exp"}, 32'(dm_exp), 0);
      chk({name, "_dm_mask"}, 32'(dm_mask), 0);
      chk({name, "_dm_tck"}, 32'(dm_tck), 0);
      chk({name, "_dm_tdo_en"}, 32'(dm_tdo_en), 0);
   endtask

   initial begin : stim
      bit hit;
      reset     = 1'b1;
      start     = 1'b0;
      bit_len   = '0;
      base_adr  = '0;
      cur_exp   = 8'h00;
      cur_mask  = 8'h00;
      flip_bits = 32'h0;
      cur_base  = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // 8 matching bits: one read, one clean write, 20 busy cycles.
      rd_q.push_back(12'h010);
      wr_adr_q.push_back(12'h010); wr_dat_q.push_back(8'h00);
      push_done(0, 0, 20);
      run_scan("len8_match", 8, 12'h010, 8'hA5, 8'hFF, 32'h0);

      // 11 bits, flips at 3 and 9. The second byte keeps only bits 0..2.
      rd_q.push_back(12'h020); rd_q.push_back(12'h021);
      wr_adr_q.push_back(12'h020); wr_dat_q.push_back(8'h08);
      wr_adr_q.push_back(12'h021); wr_dat_q.push_back(8'h02);
      push_done(2, 0, 29);
      run_scan("len11_flip", 11, 12'h020, 8'h3C, 8'hFF, 32'h0000_0208);

      // Masked-off flip: no failure recorded.
      rd_q.push_back(12'h030);
      wr_adr_q.push_back(12'h030); wr_dat_q.push_back(8'h00);
      push_done(0, 0, 20);
      run_scan("masked", 8, 12'h030, 8'h5A, 8'hF7, 32'h0000_0008);

      // Zero length: straight to DONE, one busy cycle, no memory traffic.
      push_done(0, 0, 1);
      run_scan("len0", 0, 12'h040, 8'h00, 8'hFF, 32'h0);

      // Address wraps from 0xFFF to 0x000.
      rd_q.push_back(12'hFFF); rd_q.push_back(12'h000);
      wr_adr_q.push_back(12'hFFF); wr_dat_q.push_back(8'h00);
      wr_adr_q.push_back(12'h000); wr_dat_q.push_back(8'h00);
      push_done(0, 0, 25);
      run_scan("wrap", 9, 12'hFFF, 8'hC3, 8'hFF, 32'h0);

      // 24 bits with a failure on bit 2.
`ifdef SCAN_STOP_ON_FAIL_EN
      rd_q.push_back(12'h040);
      wr_adr_q.push_back(12'h040); wr_dat_q.push_back(8'h04);
      push_done(1, 1, 11);
`else
      rd_q.push_back(12'h040); rd_q.push_back(12'h041); rd_q.push_back(12'h042);
      wr_adr_q.push_back(12'h040); wr_dat_q.push_back(8'h04);
      wr_adr_q.push_back(12'h041); wr_dat_q.push_back(8'h00);
      wr_adr_q.push_back(12'h042); wr_dat_q.push_back(8'h00);
      push_done(1, 0, 58);
`endif
      run_scan("len24_bit2", 24, 12'h040, 8'h96, 8'hFF, 32'h0000_0004);

      // Reset in THI of the second byte. The in-flight byte is never written.
      rd_q.push_back(12'h050); rd_q.push_back(12'h051);
      wr_adr_q.push_back(12'h050); wr_dat_q.push_back(8'h00);
      pulse_start(16, 12'h050, 8'h11, 8'hFF, 32'h0);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         @(negedge clk);
         if (dm_tck && mem_adr == 12'h051) hit = 1'b1;
      end
      if (!hit) begin
         checks++;
         errors++;
         $display("FAIL mid_reset_reach: got no THI in byte 2 expected one within 100 cycles");
      end
      reset = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      repeat (2) @(negedge clk);
      check_drained("mid_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Normal scan after reset release.
      rd_q.push_back(12'h060);
      wr_adr_q.push_back(12'h060); wr_dat_q.push_back(8'h80);
      push_done(1, 0, 20);
      run_scan("post_reset", 8, 12'h060, 8'h0F, 8'hFF, 32'h0000_0080);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/scan_cmp_seq.md
# scan_cmp_seq

Bit sequencer for the scan-path compare datapath in the executor. It fetches expected/mask bytes from vector memory and steps the 3-bit bit-select address of the TDI demux through each byte. It generates the TCK phases and TDO enable, and writes each completed fail byte back to memory. It also counts compare failures for one scan of programmable length and can optionally abort on the first failure.

## Interface
Parameters:
- LEN_W, 16, width of scan bit-length and fail counter
- ADDR_W, 12, width of vector/fail memory byte address

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle scan start request, sampled only in IDLE
- bit_len  in  LEN_W  scan length in bits, sampled with start
- base_adr  in  ADDR_W  first byte address, sampled with start
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- aborted  out  1  last scan stopped early on fail; valid from done until next start
- fail_cnt  out  LEN_W  failing bits in current/last scan, saturating
- mem_rd  out  1  vector read strobe; data valid the following cycle
- mem_adr  out  ADDR_W  vector/fail byte address
- mem_exp  in  8  expected byte
- mem_mask  in  8  mask byte
- fail_we  out  1  fail byte write strobe
- fail_wdata  out  8  fail byte to memory
- dm_adr  out  3  bit select to demux
- dm_exp  out  8  expected byte to demux
- dm_mask  out  8  mask byte to demux
- dm_tck  out  1  TCK phase to demux
- dm_tdo_en  out  1  compare enable to demux
- dm_fail  in  8  demux fail register
- dm_fail_flag  in  1  demux per-bit fail pulse, registered one clk after the TCK-high cycle

## Operation
- States: IDLE, FETCH, LOAD, TLO, THI, WRB, DONE.
- IDLE: start=1 and bit_len≠0 -> FETCH. Latch bit_len and base_adr. Clear fail_cnt, aborted and the bit counter. start=1 with bit_len=0 -> DONE directly, with no memory access.
- FETCH: mem_rd=1 at the current byte address -> LOAD.
- LOAD: latch mem_exp/mem_mask into dm_exp/dm_mask. Set dm_adr=0 -> TLO.
- TLO: dm_tck=0, dm_tdo_en=1 -> THI.
- THI: dm_tck=1, dm_tdo_en=1. Increment the bit counter.
  - If dm_adr=7 or this was the last bit -> WRB.
  - Otherwise increment dm_adr -> TLO.
- WRB: fail_we=1 at the current byte address. fail_wdata = dm_fail with bits above the last processed dm_adr forced to 0.
  - Remaining bits, not aborting -> increment address -> FETCH.
  - Otherwise -> DONE.
- DONE: done=1 -> IDLE.
- Fail counting: each cycle with dm_fail_flag=1 (in TLO or WRB) increments fail_cnt. fail_cnt saturates at all-ones.
- Byte address wraps modulo 2^ADDR_W. bit_len counts modulo nothing: the maximum of 2^LEN_W−1 bits is supported.
- start outside IDLE is ignored.
- reset at any time: return to IDLE. All outputs take reset values; any in-flight byte is not written.

## Timing
- Reset values: busy=0, done=0, aborted=0, fail_cnt=0, mem_rd=0, mem_adr=0, fail_we=0, fail_wdata=0, dm_adr=0, dm_exp=0, dm_mask=0, dm_tck=0, dm_tdo_en=0.
- busy is 1 in every state except IDLE, so it rises the cycle after start. busy falls after the DONE cycle.
- Each bit takes 2 clk (TLO, THI). Each byte adds 3 clk of overhead (FETCH, LOAD, WRB).
- Busy cycles for N>0 bits: 2N + 3·ceil(N/8) + 1. For N=8: 20.
- The fail flag of the last bit of a byte arrives in WRB and is counted there.

## Configuration
- SCAN_STOP_ON_FAIL_EN defined: dm_fail_flag=1 seen in TLO forces the next state to WRB. In that WRB the scan ends: the partial byte is written, the next state is DONE, and aborted=1. A flag seen in WRB also ends the scan after that write, with aborted=1, even if bits remain.
- SCAN_STOP_ON_FAIL_EN undefined: the scan always runs to bit_len, and aborted stays 0.

## Test plan
- bit_len=8, base_adr=0x010, exp=0xA5, mask=0xFF, TDI model matches -> one read at 0x010, one write of 0x00 at 0x010, fail_cnt=0, done after 20 busy cycles.
- bit_len=11, TDI model flips bits 3 and 9 with mask all-ones -> fail bytes 0x08 at base and 0x02 at base+1, fail_cnt=2. The second write has bits 3..7 forced to 0.
- Mask=0xF7 with TDI flipping bit 3 -> no fail written, fail_cnt=0.
- bit_len=0 -> done the cycle after start, no mem_rd or fail_we, busy high for one cycle.
- With SCAN_STOP_ON_FAIL_EN: bit_len=24, fail on bit 2 -> single write at base with bit 2 set, aborted=1, fail_cnt=1, no further reads. Without the macro, the same stimulus gives 3 writes and aborted=0.
- Assert reset in THI of the second byte -> all outputs at reset values the same cycle, no fail_we. A start after reset release runs a normal scan.
